// File: rtl/rom_uart_loader.sv
// Boot loader: length-prefixed UART 8N1 image -> byte-lane ROM writes; core held in reset until success. Optional checksum: LOADER_CHECKSUM_EN.
// Latency: a ROM write issues the cycle after each received byte; DONE follows the last write by one cycle.
// Backpressure: none; the ROM port must accept one write per cycle, and bytes outside a load are dropped.
module rom_uart_loader #(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          ROM_DEPTH    = 16384,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          TIMEOUT_CLKS = 5000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx_i,
    input  logic        load_req_i,
    output logic        w_en_o,
    output logic [31:0] w_addr_o,
    output logic [31:0] w_data_o,
    output logic [3:0]  w_sel_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        cpu_rst_n_o
);
    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [32:0]      MAX_BYTES = 33'(ROM_DEPTH) << 2;
    localparam logic [31:0]      TMO_END   = 32'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        rx_state;
    logic             rx_meta;
    logic             rx_sync;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_shift;
    logic             byte_valid;
    logic             framing_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta     <= 1'b1;
            rx_sync     <= 1'b1;
            rx_state    <= RX_IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            rx_shift    <= '0;
            byte_valid  <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            rx_meta     <= uart_rx_i;
            rx_sync     <= rx_meta;
            byte_valid  <= 1'b0;
            framing_err <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    clk_cnt <= '0;
                    if (!rx_sync) rx_state <= RX_START;
                end
                RX_START: begin
                    if (clk_cnt == HALF_END) begin
                        clk_cnt  <= '0;
                        bit_idx  <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (clk_cnt == BIT_END) begin
                        clk_cnt  <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        bit_idx  <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (clk_cnt == BIT_END) begin
                        clk_cnt     <= '0;
                        rx_state    <= RX_IDLE;
                        byte_valid  <= rx_sync;
                        framing_err <= !rx_sync;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
`ifdef LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t      state;
    logic [31:0] len;
    logic [1:0]  len_idx;
    logic [31:0] byte_cnt;
    logic [31:0] tmo_cnt;
    logic [31:0] len_next;
    logic        abort;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  sum;
`endif

    assign len_next = {rx_shift, len[31:8]};
    // A byte arriving on the expiry cycle takes precedence over the timeout.
    assign abort    = framing_err || (!byte_valid && tmo_cnt == TMO_END);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            len         <= '0;
            len_idx     <= '0;
            byte_cnt    <= '0;
            tmo_cnt     <= '0;
            w_en_o      <= 1'b0;
            w_addr_o    <= '0;
            w_data_o    <= '0;
            w_sel_o     <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            cpu_rst_n_o <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum         <= '0;
`endif
        end else begin
            w_en_o  <= 1'b0;
            w_sel_o <= '0;
            // Count starts at 1 on a byte so expiry lands TIMEOUT_CLKS after the byte_valid cycle.
            if (busy_o) tmo_cnt <= byte_valid ? 32'd1 : tmo_cnt + 32'd1;
            case (state)
                S_LEN: begin
                    if (abort) begin
                        state <= S_ERR; busy_o <= 1'b0; err_o <= 1'b1;
                    end else if (byte_valid) begin
                        len     <= len_next;
                        len_idx <= len_idx + 2'd1;
                        if (len_idx == 2'd3) begin
                            if (len_next == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                                state <= S_CHK;
`else
                                state <= S_DONE; busy_o <= 1'b0; done_o <= 1'b1; cpu_rst_n_o <= 1'b1;
`endif
                            end else if ({1'b0, len_next} > MAX_BYTES) begin
                                state <= S_ERR; busy_o <= 1'b0; err_o <= 1'b1;
                            end else begin
                                state <= S_DATA;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (byte_cnt == len) begin
`ifdef LOADER_CHECKSUM_EN
                        state <= S_CHK;
`else
                        state <= S_DONE; busy_o <= 1'b0; done_o <= 1'b1; cpu_rst_n_o <= 1'b1;
`endif
                    end else if (abort) begin
                        state <= S_ERR; busy_o <= 1'b0; err_o <= 1'b1;
                    end else if (byte_valid) begin
                        w_en_o   <= 1'b1;
                        w_addr_o <= BASE_ADDR + {byte_cnt[31:2], 2'b00};
                        w_sel_o  <= 4'b0001 << byte_cnt[1:0];
                        w_data_o <= {4{rx_shift}};
                        byte_cnt <= byte_cnt + 32'd1;
`ifdef LOADER_CHECKSUM_EN
                        sum      <= sum + rx_shift;
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (abort || (byte_valid && rx_shift != sum)) begin
                        state <= S_ERR; busy_o <= 1'b0; err_o <= 1'b1;
                    end else if (byte_valid) begin
                        state <= S_DONE; busy_o <= 1'b0; done_o <= 1'b1; cpu_rst_n_o <= 1'b1;
                    end
                end
`endif
                default: begin
                    if (load_req_i) begin
                        state       <= S_LEN;
                        len         <= '0;
                        len_idx     <= '0;
                        byte_cnt    <= '0;
                        tmo_cnt     <= '0;
                        busy_o      <= 1'b1;
                        done_o      <= 1'b0;
                        err_o       <= 1'b0;
                        cpu_rst_n_o <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        sum         <= '0;
`endif
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rom_uart_loader.sv
// Randomized bench for rom_uart_loader: UART images driven bit by bit, ROM writes checked against a queue of expected writes.
`timescale 1ns/1ps
module tb_rom_uart_loader;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 16384;
    localparam int          TMO   = 100;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [32:0] MAXB  = 33'(DEPTH) * 33'd4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic        load_req = 1'b0;
    logic        w_en;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic [3:0]  w_sel;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_rst_n;

    rom_uart_loader #(
        .CLKS_PER_BIT(CPB), .ROM_DEPTH(DEPTH), .BASE_ADDR(BASE), .TIMEOUT_CLKS(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .uart_rx_i(uart_rx), .load_req_i(load_req),
        .w_en_o(w_en), .w_addr_o(w_addr), .w_data_o(w_data), .w_sel_o(w_sel),
        .busy_o(busy), .done_o(done), .err_o(err), .cpu_rst_n_o(cpu_rst_n)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [7:0] img[$];
    int         n_vec = 0;
    int         n_mis = 0;
    int         cyc = 0;
    int         last_wen_cyc = -1;
    int         done_rise_cyc = -1;
    int         err_rise_cyc = -1;
    logic       done_q = 1'b0;
    logic       err_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every ROM write pops the oldest expected write.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (w_en === 1'b1) begin
                last_wen_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_mis++;
                    $display("FAIL unexpected_write: addr %0h data %0h sel %0h, no write expected", w_addr, w_data, w_sel);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("w_addr", w_addr, mon_e.addr);
                    chk("w_data", w_data, mon_e.data);
                    chk("w_sel", {28'b0, w_sel}, {28'b0, mon_e.sel});
                end
            end else if (w_sel !== 4'b0000) begin
                n_vec++;
                n_mis++;
                $display("FAIL idle_sel: got %0h, expected 0", w_sel);
            end
        end
        if (done === 1'b1 && done_q !== 1'b1) done_rise_cyc = cyc;
        if (err === 1'b1 && err_q !== 1'b1) err_rise_cyc = cyc;
        done_q = done;
        err_q  = err;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) tick();
        end
        uart_rx = stop;
        repeat (CPB) tick();
        uart_rx = 1'b1;
        if (!stop) repeat (2 * CPB) tick();
    endtask

    task automatic pulse_req();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic fill_img(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic push_exp(input int k, input logic [7:0] b);
        wr_t w;
        w.addr = BASE + 32'((k / 4) * 4);
        w.data = {b, b, b, b};
        w.sel  = 4'(1 << (k % 4));
        exp_q.push_back(w);
    endtask

    task automatic settle(input bit ok, input logic [31:0] n);
        int t;
        t = 0;
        while (busy === 1'b1 && t < 3000) begin
            tick();
            t++;
        end
        repeat (2) tick();
        chk("busy_end", {31'b0, busy}, 32'd0);
        chk("done", {31'b0, done}, {31'b0, ok});
        chk("err", {31'b0, err}, {31'b0, !ok});
        chk("cpu_rst_n", {31'b0, cpu_rst_n}, {31'b0, ok});
        chk("pending_writes", exp_q.size(), 32'd0);
`ifndef LOADER_CHECKSUM_EN
        if (ok && n != 0) chk("done_latency", done_rise_cyc - last_wen_cyc, 32'd1);
`endif
        exp_q.delete();
    endtask

    // bad: index of the byte sent with a low stop bit (-1 for none); cbad corrupts the checksum byte.
    task automatic do_load(input logic [31:0] n, input int bad, input bit cbad);
        bit         in_range;
        bit         ok;
        logic [7:0] s;
        in_range = ({1'b0, n} <= MAXB);
        ok       = in_range;
        s        = 8'h00;
        pulse_req();
        chk("busy_on_req", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], 1'b1);
        if (in_range) begin
            for (int k = 0; k < int'(n); k++) begin
                if (k == bad) begin
                    send_byte(img[k], 1'b0);
                    ok = 1'b0;
                    break;
                end
                push_exp(k, img[k]);
                s = s + img[k];
                send_byte(img[k], 1'b1);
            end
`ifdef LOADER_CHECKSUM_EN
            if (ok) begin
                send_byte(s + 8'(cbad), 1'b1);
                if (cbad) ok = 1'b0;
            end
`endif
        end
        settle(ok, n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int n;
        int bad;
        repeat (5) tick();
        chk("rst_w_en", {31'b0, w_en}, 32'd0);
        chk("rst_w_addr", w_addr, 32'd0);
        chk("rst_w_data", w_data, 32'd0);
        chk("rst_w_sel", {28'b0, w_sel}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_cpu_rst_n", {31'b0, cpu_rst_n}, 32'd0);
        rst_n = 1'b1;
        repeat (3) tick();

        img = '{8'h13, 8'h00, 8'h00, 8'h00};
        do_load(32'd4, -1, 1'b0);
        img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        do_load(32'd6, -1, 1'b0);
        img.delete();
        do_load(32'd0, -1, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        do_load(32'd0, -1, 1'b1);
`endif
        fill_img(4);
        do_load(32'd4, 1, 1'b0);
        fill_img(5);
        do_load(32'd5, -1, 1'b0);
        do_load(32'd65537, -1, 1'b0);

        for (int r = 0; r < 6; r++) begin
            n   = $urandom_range(1, 9);
            bad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            fill_img(n);
            do_load(32'(n), bad, ($urandom_range(0, 3) == 0));
        end

        // Inter-byte timeout, with a load request mid-DATA that must be ignored.
        fill_img(2);
        err_rise_cyc = -1;
        pulse_req();
        send_byte(8'h08, 1'b1);
        for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
        push_exp(0, img[0]);
        send_byte(img[0], 1'b1);
        pulse_req();
        push_exp(1, img[1]);
        send_byte(img[1], 1'b1);
        t = 0;
        while (err !== 1'b1 && t < 400) begin
            tick();
            t++;
        end
        tick();
        chk("tmo_err", {31'b0, err}, 32'd1);
        chk("tmo_latency", err_rise_cyc - last_wen_cyc, 32'd99);
        chk("tmo_cpu_rst_n", {31'b0, cpu_rst_n}, 32'd0);
        chk("tmo_pending", exp_q.size(), 32'd0);
        exp_q.delete();

        // Reset in the middle of DATA.
        fill_img(4);
        img[0] = 8'($urandom_range(1, 255));
        pulse_req();
        send_byte(8'h04, 1'b1);
        for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
        push_exp(0, img[0]);
        send_byte(img[0], 1'b1);
        repeat (3) tick();
        chk("mid_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        tick();
        chk("mrst_w_en", {31'b0, w_en}, 32'd0);
        chk("mrst_w_addr", w_addr, 32'd0);
        chk("mrst_w_data", w_data, 32'd0);
        chk("mrst_w_sel", {28'b0, w_sel}, 32'd0);
        chk("mrst_busy", {31'b0, busy}, 32'd0);
        chk("mrst_done", {31'b0, done}, 32'd0);
        chk("mrst_err", {31'b0, err}, 32'd0);
        chk("mrst_cpu_rst_n", {31'b0, cpu_rst_n}, 32'd0);
        chk("mrst_pending", exp_q.size(), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        fill_img(7);
        do_load(32'd7, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
